// File: rtl/dataTypes_pkg.sv
// Shared playback types: scheduler states and control helpers.
package dataTypes_pkg;

  typedef logic [2:0] schedState_t;

  localparam schedState_t S_IDLE    = 3'd0;
  localparam schedState_t S_RESTART = 3'd1;
  localparam schedState_t S_ARM     = 3'd2;
  localparam schedState_t S_RUN     = 3'd3;
  localparam schedState_t S_DONE    = 3'd4;
  localparam schedState_t S_ABORT   = 3'd5;

  typedef struct packed {
    logic resetN;
    logic enable;
  } pbCtrl_t;

  function automatic pbCtrl_t pb_ctrl(schedState_t s);
    pbCtrl_t c;
    c.resetN = (s != S_RESTART) && (s != S_ABORT);
    c.enable = (s == S_ARM) || (s == S_RUN);
    return c;
  endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period divider: one-cycle tick every div+1 cycles while run is high.
module bit_tick_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick = run && (cnt_q == div);

  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (run)
      cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/playback_sched.sv
// Playback command scheduler: restart, arm, bit-tick run, done.
// Optional underrun abort enabled by PLAYBACK_UNDERRUN_CHECK_EN.
module playback_sched
  import dataTypes_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int DIV_W   = 16,
  parameter int RST_CYC = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmdValid,
  output logic             cmdReady,
  input  logic [CNT_W-1:0] cmdCount,
  input  logic [DIV_W-1:0] cmdBitDiv,
  output logic             pbResetN,
  output logic             pbEnable,
  output logic [CNT_W-1:0] pbRequestNum,
  output logic             pbClk,
  input  logic             pbComplete,
  input  logic             pbAdvFIFO,
  input  logic             fifoEmpty,
  output logic             busy,
  output logic             errUnderrun
);

  localparam logic [3:0] RST_LAST = 4'(RST_CYC - 1);

  schedState_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       rcnt_q, rcnt_d;
  logic             err_d;
  logic             accept;
  logic             underrun;
  logic             tick;
  pbCtrl_t          ctrl;

  assign accept = cmdValid && cmdReady;

`ifdef PLAYBACK_UNDERRUN_CHECK_EN
  logic err_q;
  assign underrun    = pbAdvFIFO && fifoEmpty;
  assign errUnderrun = err_q;
`else
  logic unused_fifo;
  assign unused_fifo = pbAdvFIFO ^ fifoEmpty;
  assign underrun    = 1'b0;
  assign errUnderrun = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    rcnt_d  = rcnt_q;
    err_d   = errUnderrun;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          err_d = 1'b0;
          // Zero-length commands are swallowed without a restart
          if (cmdCount != '0) begin
            cnt_d   = cmdCount;
            div_d   = cmdBitDiv;
            rcnt_d  = '0;
            state_d = S_RESTART;
          end
        end
      end
      S_RESTART: begin
        if (rcnt_q == RST_LAST)
          state_d = S_ARM;
        else
          rcnt_d = rcnt_q + 1'b1;
      end
      S_ARM: state_d = S_RUN;
      S_RUN: begin
        if (underrun) begin
          err_d   = 1'b1;
          state_d = S_ABORT;
        end else if (pbComplete) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      rcnt_q  <= rcnt_d;
    end
  end

`ifdef PLAYBACK_UNDERRUN_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end
`else
  logic unused_err;
  assign unused_err = err_d;
`endif

  bit_tick_gen #(
    .DIV_W(DIV_W)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clear(state_q == S_ARM),
    .run  (state_q == S_RUN),
    .div  (div_q),
    .tick (tick)
  );

  assign ctrl         = pb_ctrl(state_q);
  assign pbClk        = tick;
  assign pbEnable     = ctrl.enable;
  assign pbResetN     = ctrl.resetN && !reset;
  assign pbRequestNum = cnt_q;
  assign busy         = (state_q != S_IDLE);
  assign cmdReady     = (state_q == S_IDLE) && !reset;

endmodule
